// File: rtl/vc_dest_arbiter_if.sv
// FIFO-side bundle of the VC/destination arbiter: VC FIFO heads and flags,
// destination FIFO flags, and the pop/push/data signals the arbiter drives.
interface vc_dest_arbiter_if #(
  parameter int DATA_SIZE = 10
);
  logic                 vc0_empty;
  logic                 vc1_empty;
  logic [DATA_SIZE-1:0] vc0_data;
  logic [DATA_SIZE-1:0] vc1_data;
  logic                 d0_almost_full;
  logic                 d1_almost_full;
  logic                 d0_empty;
  logic                 d1_empty;
  logic                 pop_vc0;
  logic                 pop_vc1;
  logic                 push_d0;
  logic                 push_d1;
  logic [DATA_SIZE-1:0] data_out;

  // Arbiter side
  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_almost_full, d1_almost_full, d0_empty, d1_empty,
    output pop_vc0, pop_vc1, push_d0, push_d1, data_out
  );

  // FIFO side
  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_almost_full, d1_almost_full, d0_empty, d1_empty,
    input  pop_vc0, pop_vc1, push_d0, push_d1, data_out
  );
endinterface

// File: rtl/vc_dest_arbiter.sv
// Arbiter between virtual-channel FIFOs VC0/VC1 and destination FIFOs D0/D1.
// Holds the FIFO thresholds (loaded in INIT), pops VC0 with strict priority
// over VC1, steers each word by its dest bit, honours destination
// almost-full backpressure and flags idle once the datapath has drained.
module vc_dest_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int DEST_BIT  = 8,
  parameter int TH_SIZE   = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               init,
  input  logic [TH_SIZE-1:0] afVC_in,
  input  logic [TH_SIZE-1:0] aeVC_in,
  input  logic [TH_SIZE-1:0] afD_in,
  input  logic [TH_SIZE-1:0] aeD_in,
  vc_dest_arbiter_if.master  fifo,
  output logic [TH_SIZE-1:0] afVC,
  output logic [TH_SIZE-1:0] aeVC,
  output logic [TH_SIZE-1:0] afD,
  output logic [TH_SIZE-1:0] aeD,
  output logic               idle,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_next;

  logic                 pop0;
  logic                 pop1;
  logic                 any_pop;
  logic                 head0_blocked;
  logic                 head1_blocked;
  logic [DATA_SIZE-1:0] pop_word;

  // Stage 1 registers: word and its push strobe, one cycle after the pop.
  logic [DATA_SIZE-1:0] data_p1;
  logic                 push0_p1;
  logic                 push1_p1;
  logic                 idle_q;

  logic [TH_SIZE-1:0]   af_vc_q;
  logic [TH_SIZE-1:0]   ae_vc_q;
  logic [TH_SIZE-1:0]   af_d_q;
  logic [TH_SIZE-1:0]   ae_d_q;

  // Arbitration: VC0 wins unless empty or its head's destination is almost full
  always_comb begin
    head0_blocked = fifo.vc0_data[DEST_BIT] ? fifo.d1_almost_full : fifo.d0_almost_full;
    head1_blocked = fifo.vc1_data[DEST_BIT] ? fifo.d1_almost_full : fifo.d0_almost_full;
    pop0          = 1'b0;
    pop1          = 1'b0;
    if (state_q == ST_ACTIVE && !init) begin
      pop0 = !fifo.vc0_empty && !head0_blocked;
      pop1 = !fifo.vc1_empty && !head1_blocked && !pop0;
    end
    any_pop  = pop0 | pop1;
    pop_word = pop0 ? fifo.vc0_data : fifo.vc1_data;
  end

  // Next-state logic; init from any operating state returns to INIT
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT:   if (!init) state_next = ST_IDLE;
      ST_IDLE: begin
        if (init)
          state_next = ST_INIT;
        else if (!fifo.vc0_empty || !fifo.vc1_empty)
          state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)
          state_next = ST_INIT;
        else if (fifo.vc0_empty && fifo.vc1_empty && !any_pop)
          state_next = ST_IDLE;
      end
      default:   state_next = ST_RESET;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_next;
  end

  // Threshold registers track the inputs on every edge spent in INIT
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      af_vc_q <= '0;
      ae_vc_q <= '0;
      af_d_q  <= '0;
      ae_d_q  <= '0;
    end else if (state_q == ST_INIT) begin
      af_vc_q <= afVC_in;
      ae_vc_q <= aeVC_in;
      af_d_q  <= afD_in;
      ae_d_q  <= aeD_in;
    end
  end

  // Stage 0 -> 1: register the popped word and raise the push for its destination
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_p1  <= '0;
      push0_p1 <= 1'b0;
      push1_p1 <= 1'b0;
    end else begin
      if (any_pop) data_p1 <= pop_word;
      push0_p1 <= any_pop && !pop_word[DEST_BIT];
      push1_p1 <= any_pop &&  pop_word[DEST_BIT];
    end
  end

  // Idle: heading into IDLE with every FIFO empty and no push still in flight
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      idle_q <= 1'b0;
    end else begin
      idle_q <= (state_next == ST_IDLE) && fifo.vc0_empty && fifo.vc1_empty &&
                fifo.d0_empty && fifo.d1_empty && !push0_p1 && !push1_p1;
    end
  end

  assign fifo.pop_vc0  = pop0;
  assign fifo.pop_vc1  = pop1;
  assign fifo.push_d0  = push0_p1;
  assign fifo.push_d1  = push1_p1;
  assign fifo.data_out = data_p1;
  assign afVC          = af_vc_q;
  assign aeVC          = ae_vc_q;
  assign afD           = af_d_q;
  assign aeD           = ae_d_q;
  assign idle          = idle_q;
  assign state         = state_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Testbench for vc_dest_arbiter: queue-modelled VC and destination FIFOs
// around the DUT, with a cycle-level reference model of the arbiter rules.
module tb_vc_dest_arbiter;
  localparam int DW = 10;
  localparam int TW = 4;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          init = 1'b0;
  logic [TW-1:0] afVC_in = '0, aeVC_in = '0, afD_in = '0, aeD_in = '0;
  logic [TW-1:0] afVC, aeVC, afD, aeD;
  logic          idle;
  logic [1:0]    state;

  vc_dest_arbiter_if #(.DATA_SIZE(DW)) bus ();

  vc_dest_arbiter #(.DATA_SIZE(DW), .DEST_BIT(8), .TH_SIZE(TW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .afVC_in(afVC_in), .aeVC_in(aeVC_in), .afD_in(afD_in), .aeD_in(aeD_in),
    .fifo(bus),
    .afVC(afVC), .aeVC(aeVC), .afD(afD), .aeD(aeD),
    .idle(idle), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] vc0_q[$], vc1_q[$], d0_q[$], d1_q[$];
  int feed_pct  = 0;
  int drain_pct = 100;
  int af0_mode  = 0;  // 0 low, 1 high, 2 random
  int af1_mode  = 0;

  // reference model state
  int            mstate = S_RESET;
  logic          epush0 = 1'b0, epush1 = 1'b0;
  logic [DW-1:0] edata = '0;
  logic          eidle = 1'b0;
  logic [15:0]   eth = '0;

  function automatic logic [DW-1:0] mkword(input logic dest);
    logic [DW-1:0] w;
    w = DW'($urandom);
    w[8] = dest;
    return w;
  endfunction

  function automatic logic af_val(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic apply_inputs();
    bus.vc0_empty      = (vc0_q.size() == 0);
    bus.vc1_empty      = (vc1_q.size() == 0);
    bus.vc0_data       = bus.vc0_empty ? DW'($urandom) : vc0_q[0];
    bus.vc1_data       = bus.vc1_empty ? DW'($urandom) : vc1_q[0];
    bus.d0_empty       = (d0_q.size() == 0);
    bus.d1_empty       = (d1_q.size() == 0);
    bus.d0_almost_full = af_val(af0_mode);
    bus.d1_almost_full = af_val(af1_mode);
  endtask

  task automatic new_cycle_inputs();
    if ($urandom_range(1, 100) <= feed_pct) vc0_q.push_back(mkword(1'($urandom)));
    if ($urandom_range(1, 100) <= feed_pct) vc1_q.push_back(mkword(1'($urandom)));
    apply_inputs();
  endtask

  // One clock cycle: check DUT against the model, then advance model and FIFOs.
  task automatic step();
    logic xp0, xp1, b0, b1, n_push0, n_push1, n_idle;
    logic [DW-1:0] w;
    logic [15:0] n_th;
    int nxt;
    #1;
    xp0 = 1'b0;
    xp1 = 1'b0;
    if (mstate == S_ACTIVE && !init) begin
      b0  = bus.vc0_data[8] ? bus.d1_almost_full : bus.d0_almost_full;
      b1  = bus.vc1_data[8] ? bus.d1_almost_full : bus.d0_almost_full;
      xp0 = !bus.vc0_empty && !b0;
      xp1 = !bus.vc1_empty && !b1 && !xp0;
    end
    total++;
    if ({bus.pop_vc1, bus.pop_vc0} !== {xp1, xp0}) begin
      bad++; $display("FAIL pops t=%0t got=%b want=%b", $time, {bus.pop_vc1, bus.pop_vc0}, {xp1, xp0});
    end
    total++;
    if ({bus.push_d1, bus.push_d0} !== {epush1, epush0}) begin
      bad++; $display("FAIL pushes t=%0t got=%b want=%b", $time, {bus.push_d1, bus.push_d0}, {epush1, epush0});
    end
    total++;
    if (bus.data_out !== edata) begin
      bad++; $display("FAIL data_out t=%0t got=%h want=%h", $time, bus.data_out, edata);
    end
    total++;
    if (state !== 2'(mstate)) begin
      bad++; $display("FAIL state t=%0t got=%0d want=%0d", $time, state, mstate);
    end
    total++;
    if (idle !== eidle) begin
      bad++; $display("FAIL idle t=%0t got=%b want=%b", $time, idle, eidle);
    end
    total++;
    if ({afVC, aeVC, afD, aeD} !== eth) begin
      bad++; $display("FAIL thresholds t=%0t got=%h want=%h", $time, {afVC, aeVC, afD, aeD}, eth);
    end

    nxt = mstate;
    case (mstate)
      S_RESET:  nxt = S_INIT;
      S_INIT:   nxt = init ? S_INIT : S_IDLE;
      S_IDLE:   nxt = init ? S_INIT : ((vc0_q.size() + vc1_q.size()) > 0 ? S_ACTIVE : S_IDLE);
      default:  nxt = init ? S_INIT : ((vc0_q.size() + vc1_q.size() == 0) ? S_IDLE : S_ACTIVE);
    endcase
    n_idle = (nxt == S_IDLE) && bus.vc0_empty && bus.vc1_empty &&
             bus.d0_empty && bus.d1_empty && !epush0 && !epush1;
    n_th = (mstate == S_INIT) ? {afVC_in, aeVC_in, afD_in, aeD_in} : eth;
    w = edata;
    if (xp0)      w = vc0_q.pop_front();
    else if (xp1) w = vc1_q.pop_front();
    n_push0 = (xp0 || xp1) && !w[8];
    n_push1 = (xp0 || xp1) &&  w[8];
    if (d0_q.size() > 0 && $urandom_range(1, 100) <= drain_pct) void'(d0_q.pop_front());
    if (d1_q.size() > 0 && $urandom_range(1, 100) <= drain_pct) void'(d1_q.pop_front());
    if (epush0) d0_q.push_back(edata);
    if (epush1) d1_q.push_back(edata);

    @(posedge clk);
    mstate = nxt;
    epush0 = n_push0;
    epush1 = n_push1;
    edata  = w;
    eidle  = n_idle;
    eth    = n_th;
    @(negedge clk);
    new_cycle_inputs();
  endtask

  task automatic do_reset(input int n);
    reset_L = 1'b0;
    mstate = S_RESET; epush0 = 1'b0; epush1 = 1'b0; edata = '0; eidle = 1'b0; eth = '0;
    vc0_q.delete(); vc1_q.delete(); d0_q.delete(); d1_q.delete();
    apply_inputs();
    repeat (n) begin
      @(negedge clk);
      #1;
      total++;
      if ({bus.pop_vc1, bus.pop_vc0, bus.push_d1, bus.push_d0, idle} !== 5'b0) begin
        bad++; $display("FAIL reset_strobes got=%b want=00000", {bus.pop_vc1, bus.pop_vc0, bus.push_d1, bus.push_d0, idle});
      end
      total++;
      if ({state, bus.data_out, afVC, aeVC, afD, aeD} !== {2'(mstate), edata, eth}) begin
        bad++; $display("FAIL reset_regs got=%h want=%h", {state, bus.data_out, afVC, aeVC, afD, aeD}, {2'(mstate), edata, eth});
      end
    end
  endtask

  task automatic bring_up();
    init = 1'b1;
    reset_L = 1'b1;
    apply_inputs();
    step();
    step();
    init = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset(2);
  endtask

  task automatic test_init();
    init = 1'b1;
    {afVC_in, aeVC_in, afD_in, aeD_in} = 16'h1278;
    reset_L = 1'b1;
    apply_inputs();
    step();  // RESET -> INIT
    step();  // INIT, loads 1/2/7/8
    init = 1'b0;
    {afVC_in, aeVC_in, afD_in, aeD_in} = 16'h6453;
    step();  // INIT -> IDLE, last load
    {afVC_in, aeVC_in, afD_in, aeD_in} = 16'hFFFF;
    step();
    total++;
    if ({afVC, aeVC, afD, aeD} !== 16'h6453) begin
      bad++; $display("FAIL init_thresholds got=%h want=6453", {afVC, aeVC, afD, aeD});
    end
  endtask

  task automatic test_routing();
    feed_pct = 0; drain_pct = 100; af0_mode = 0; af1_mode = 0;
    vc0_q.push_back(10'h1AB);
    vc0_q.push_back(10'h0BB);
    apply_inputs();
    step();  // IDLE -> ACTIVE
    step();  // pop 0x1AB
    #1;
    total++;
    if ({bus.push_d1, bus.push_d0, bus.data_out} !== {2'b10, 10'h1AB}) begin
      bad++; $display("FAIL routing_first got=%h want=%h", {bus.push_d1, bus.push_d0, bus.data_out}, {2'b10, 10'h1AB});
    end
    step();  // pop 0x0BB
    #1;
    total++;
    if ({bus.push_d1, bus.push_d0, bus.data_out} !== {2'b01, 10'h0BB}) begin
      bad++; $display("FAIL routing_second got=%h want=%h", {bus.push_d1, bus.push_d0, bus.data_out}, {2'b01, 10'h0BB});
    end
    repeat (4) step();
  endtask

  task automatic test_priority();
    int viol;
    viol = 0;
    for (int i = 0; i < 4; i++) vc0_q.push_back(mkword(1'b0));
    for (int i = 0; i < 3; i++) vc1_q.push_back(mkword(1'b0));
    apply_inputs();
    repeat (12) begin
      #1;
      if (bus.pop_vc1 && vc0_q.size() != 0) viol++;
      if (bus.pop_vc1 && bus.pop_vc0) viol++;
      step();
    end
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL priority violations=%0d want=0", viol);
    end
  endtask

  task automatic test_bypass();
    af0_mode = 0; af1_mode = 1;
    vc0_q.push_back(10'h155);
    vc1_q.push_back(10'h022);
    vc1_q.push_back(10'h033);
    apply_inputs();
    step();  // IDLE -> ACTIVE
    #1;
    total++;
    if ({bus.pop_vc1, bus.pop_vc0} !== 2'b10) begin
      bad++; $display("FAIL bypass_pop got=%b want=10", {bus.pop_vc1, bus.pop_vc0});
    end
    step();
    #1;
    total++;
    if ({bus.push_d1, bus.push_d0, bus.data_out} !== {2'b01, 10'h022}) begin
      bad++; $display("FAIL bypass_push got=%h want=%h", {bus.push_d1, bus.push_d0, bus.data_out}, {2'b01, 10'h022});
    end
    step();
    af1_mode = 0;
    apply_inputs();
    #1;
    total++;
    if ({bus.pop_vc1, bus.pop_vc0} !== 2'b01) begin
      bad++; $display("FAIL bypass_resume got=%b want=01", {bus.pop_vc1, bus.pop_vc0});
    end
    repeat (4) step();
  endtask

  task automatic test_init_mid();
    feed_pct = 100; af0_mode = 0; af1_mode = 0;
    repeat (6) step();
    init = 1'b1;
    {afVC_in, aeVC_in, afD_in, aeD_in} = 16'h9A5C;
    #1;
    total++;
    if ({bus.pop_vc1, bus.pop_vc0} !== 2'b00) begin
      bad++; $display("FAIL init_mid_pops got=%b want=00", {bus.pop_vc1, bus.pop_vc0});
    end
    step();
    #1;
    total++;
    if ({state, bus.push_d1, bus.push_d0} !== {2'(S_INIT), 2'b00}) begin
      bad++; $display("FAIL init_mid_state got=%b want=%b", {state, bus.push_d1, bus.push_d0}, {2'(S_INIT), 2'b00});
    end
    step();
    init = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    int n;
    feed_pct = 100;
    n = 0;
    while (!(epush0 || epush1) && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!(epush0 || epush1)) begin
      bad++; $display("FAIL reset_mid_no_push got=0 want=1");
    end
    #2;
    reset_L = 1'b0;
    #1;
    total++;
    if ({bus.push_d1, bus.push_d0, bus.data_out, state} !== '0) begin
      bad++; $display("FAIL reset_mid_async got=%h want=0", {bus.push_d1, bus.push_d0, bus.data_out, state});
    end
    feed_pct = 0;
    do_reset(2);
    {afVC_in, aeVC_in, afD_in, aeD_in} = 16'h6453;
    bring_up();
  endtask

  task automatic test_idle();
    int n;
    feed_pct = 30; drain_pct = 60;
    repeat (20) step();
    feed_pct = 0; drain_pct = 100;
    n = 0;
    while (!(mstate == S_IDLE && eidle) && n < 80) begin
      step();
      n++;
    end
    #1;
    total++;
    if ({state, idle} !== {2'(S_IDLE), 1'b1}) begin
      bad++; $display("FAIL idle_drained got=%b want=%b", {state, idle}, {2'(S_IDLE), 1'b1});
    end
    vc0_q.push_back(mkword(1'b0));
    apply_inputs();
    step();
    #1;
    total++;
    if ({state, idle} !== {2'(S_ACTIVE), 1'b0}) begin
      bad++; $display("FAIL idle_wake got=%b want=%b", {state, idle}, {2'(S_ACTIVE), 1'b0});
    end
    repeat (4) step();
  endtask

  task automatic test_random();
    int init_cnt;
    init_cnt = 0;
    feed_pct = 35; drain_pct = 50; af0_mode = 2; af1_mode = 2;
    for (int i = 0; i < 800; i++) begin
      if (init_cnt > 0) init_cnt--;
      else if ($urandom_range(0, 79) == 0) init_cnt = $urandom_range(1, 3);
      init = (init_cnt > 0);
      {afVC_in, aeVC_in, afD_in, aeD_in} = 16'($urandom);
      step();
    end
    init = 1'b0;
    af0_mode = 0; af1_mode = 0; feed_pct = 0; drain_pct = 100;
    repeat (60) step();
  endtask

  initial begin
    apply_inputs();
    test_reset();
    test_init();
    test_routing();
    test_priority();
    test_bypass();
    test_init_mid();
    test_reset_mid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
